// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// alu_cmd_sequencer: single-outstanding command initiator for the ALU.
// Screens illegal opcodes and divide-by-zero, waits the opcode latency, returns a tagged response.
module alu_cmd_sequencer #(
    parameter int N       = 32,
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic [3:0]       cmd_opcode,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [N-1:0]     alu_result,
    input  logic [N-1:0]     alu_remainder,
    input  logic             alu_carry_out,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic [N-1:0]     rsp_remainder,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [15:0]      err_count
);
    localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_err;
    logic [TAG_W-1:0] r_tag;
    logic             w_accept;
    logic             w_err;
    logic [CW-1:0]    w_lat;

    assign w_accept = r_state == IDLE && cmd_valid && cmd_ready;
    assign w_err    = cmd_opcode > OP_DIV || (cmd_opcode == OP_DIV && cmd_b == '0);
    // counter holds remaining wait edges, so an L-cycle op loads L-1
    assign w_lat    = w_err ? '0 :
                      cmd_opcode == OP_MUL ? CW'(MUL_LAT - 1) :
                      cmd_opcode == OP_DIV ? CW'(DIV_LAT - 1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            r_tag         <= '0;
            cmd_ready     <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_opcode    <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_remainder <= '0;
            rsp_flags     <= '0;
            rsp_tag       <= '0;
            rsp_err       <= 1'b0;
            err_count     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (w_accept) begin
                        cmd_ready <= 1'b0;
                        r_tag     <= cmd_tag;
                        r_err     <= w_err;
                        r_cnt     <= w_lat;
                        r_state   <= WAIT;
                        if (!w_err) begin
                            alu_a      <= cmd_a;
                            alu_b      <= cmd_b;
                            alu_opcode <= cmd_opcode;
                        end else if (err_count != '1) begin
                            err_count <= err_count + 16'd1;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        rsp_valid     <= 1'b1;
                        rsp_result    <= r_err ? '0 : alu_result;
                        rsp_remainder <= r_err ? '0 : alu_remainder;
                        rsp_flags     <= r_err ? 3'b000 : {alu_overflow, alu_carry_out, alu_zero};
                        rsp_tag       <= r_tag;
                        rsp_err       <= r_err;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
// tb_alu_cmd_sequencer: directed vector table, reset/back-pressure sequences and a
// randomized back-to-back run checked against a request-level model with a behavioural ALU.
module tb_alu_cmd_sequencer;
    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_XOR = 4'd2, OP_NOT = 4'd3,
                           OP_NEGA = 4'd4, OP_NEGB = 4'd5, OP_ADD = 4'd6, OP_SUB = 4'd7,
                           OP_MUL = 4'd8, OP_DIV = 4'd9;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] rem;
        logic [2:0]  f;
    } res_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        int          hold;
        bit          early;
        logic [31:0] er;
        logic [31:0] erem;
        logic [2:0]  ef;
        bit          eerr;
        int          elat;
    } vec_t;

    typedef struct {
        res_t       r;
        logic       err;
        logic [3:0] tag;
        int         lat;
    } exp_t;

    logic        clk, rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, alu_remainder, rsp_result, rsp_remainder;
    logic [3:0]  cmd_opcode, cmd_tag, alu_opcode, rsp_tag;
    logic        alu_carry_out, alu_zero, alu_overflow;
    logic [2:0]  rsp_flags;
    logic [15:0] err_count;
    res_t        alu_out;

    int   total = 0;
    int   bad = 0;
    logic [15:0] errs = '0;

    alu_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_remainder(alu_remainder),
        .alu_carry_out(alu_carry_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_remainder(rsp_remainder), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .err_count(err_count)
    );

    // Behavioural ALU: flags are {overflow, carry/borrow, zero}
    function automatic res_t alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t o;
        logic [32:0] s;
        o = '0;
        s = '0;
        case (op)
            OP_AND:  o.r = a & b;
            OP_OR:   o.r = a | b;
            OP_XOR:  o.r = a ^ b;
            OP_NOT:  o.r = ~a;
            OP_NEGA: o.r = -a;
            OP_NEGB: o.r = -b;
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                o.r = s[31:0];
                o.f[1] = s[32];
                o.f[2] = (a[31] == b[31]) && (o.r[31] != a[31]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                o.r = s[31:0];
                o.f[1] = s[32];
                o.f[2] = (a[31] != b[31]) && (o.r[31] != a[31]);
            end
            OP_MUL: o.r = a * b;
            OP_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) o.r = a;
                else if (b != 0) begin
                    o.r   = $signed(a) / $signed(b);
                    o.rem = $signed(a) % $signed(b);
                end
            end
            default: o.r = '0;
        endcase
        o.f[0] = o.r == 0;
        return o;
    endfunction

    function automatic bit is_err(input logic [3:0] op, input logic [31:0] b);
        return op > OP_DIV || (op == OP_DIV && b == 0);
    endfunction

    function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
        if (is_err(op, b)) return 1;
        return op == OP_MUL ? 4 : op == OP_DIV ? 34 : 1;
    endfunction

    assign alu_out       = alu_fn(alu_opcode, alu_a, alu_b);
    assign alu_result    = alu_out.r;
    assign alu_remainder = alu_out.rem;
    assign alu_overflow  = alu_out.f[2];
    assign alu_carry_out = alu_out.f[1];
    assign alu_zero      = alu_out.f[0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input vec_t v);
        logic [31:0] pa, pb;
        logic [3:0]  pop;
        int n;
        bit acc;
        pa = alu_a; pb = alu_b; pop = alu_opcode;
        cmd_valid = 1'b1; cmd_opcode = v.op; cmd_a = v.a; cmd_b = v.b; cmd_tag = v.tag;
        n = 0; acc = 0;
        while (!acc && n < 50) begin
            acc = cmd_ready;
            tick();
            n++;
        end
        chk("accept", 32'(acc), 32'd1);
        if (v.eerr && errs != 16'hFFFF) errs++;
        // garbage commands while busy must be ignored
        cmd_a = $urandom; cmd_b = $urandom; cmd_opcode = 4'($urandom); cmd_tag = 4'($urandom);
        if (v.early) rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 100) begin
            chk("busy_ready", 32'(cmd_ready), 32'd0);
            if (!v.eerr) chk("wait_opcode", 32'(alu_opcode), 32'(v.op));
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("latency", n, v.elat);
        chk("rsp_ready_low", 32'(cmd_ready), 32'd0);
        chk("result", rsp_result, v.er);
        chk("remainder", rsp_remainder, v.erem);
        chk("flags", 32'(rsp_flags), 32'(v.ef));
        chk("tag", 32'(rsp_tag), 32'(v.tag));
        chk("err", 32'(rsp_err), 32'(v.eerr));
        chk("err_count", 32'(err_count), 32'(errs));
        chk("alu_a", alu_a, v.eerr ? pa : v.a);
        chk("alu_b", alu_b, v.eerr ? pb : v.b);
        chk("alu_opcode", 32'(alu_opcode), 32'(v.eerr ? pop : v.op));
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_result", rsp_result, v.er);
            chk("hold_rem", rsp_remainder, v.erem);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic new_cmd();
        cmd_opcode = 4'($urandom_range(0, 15));
        cmd_a = $urandom;
        cmd_b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        if (cmd_opcode == OP_DIV && $urandom_range(0, 1) == 1) begin
            cmd_a = 32'($urandom_range(0, 1000));
            cmd_b = 32'($urandom_range(0, 20));
        end
        cmd_tag = 4'($urandom);
    endtask

    vec_t vt[17];
    exp_t q[$];
    exp_t e;

    initial begin
        vt[0]  = '{OP_ADD,  32'd5,          32'd7,          4'd3,  0,  1'b1, 32'd12,         32'd0,          3'b000, 1'b0, 1};
        vt[1]  = '{OP_MUL,  32'hFFFF_FFFF,  32'd3,          4'd5,  0,  1'b0, 32'hFFFF_FFFD,  32'd0,          3'b000, 1'b0, 4};
        vt[2]  = '{OP_DIV,  32'd100,        32'd0,          4'd6,  0,  1'b0, 32'd0,          32'd0,          3'b000, 1'b1, 1};
        vt[3]  = '{4'hC,    32'd1,          32'd2,          4'd7,  0,  1'b0, 32'd0,          32'd0,          3'b000, 1'b1, 1};
        vt[4]  = '{OP_DIV,  32'd17,         32'd5,          4'd8,  10, 1'b0, 32'd3,          32'd2,          3'b000, 1'b0, 34};
        vt[5]  = '{OP_SUB,  32'd3,          32'd5,          4'd9,  0,  1'b0, 32'hFFFF_FFFE,  32'd0,          3'b010, 1'b0, 1};
        vt[6]  = '{OP_XOR,  32'h0000_F0F0,  32'h0000_F0F0,  4'd10, 0,  1'b0, 32'd0,          32'd0,          3'b001, 1'b0, 1};
        vt[7]  = '{OP_ADD,  32'h7FFF_FFFF,  32'd1,          4'd11, 2,  1'b0, 32'h8000_0000,  32'd0,          3'b100, 1'b0, 1};
        vt[8]  = '{OP_ADD,  32'hFFFF_FFFF,  32'd1,          4'd12, 0,  1'b0, 32'd0,          32'd0,          3'b011, 1'b0, 1};
        vt[9]  = '{OP_NOT,  32'd0,          32'd9,          4'd13, 0,  1'b0, 32'hFFFF_FFFF,  32'd0,          3'b000, 1'b0, 1};
        vt[10] = '{OP_NEGA, 32'd5,          32'd9,          4'd14, 0,  1'b0, 32'hFFFF_FFFB,  32'd0,          3'b000, 1'b0, 1};
        vt[11] = '{OP_NEGB, 32'd9,          32'd1,          4'd15, 0,  1'b0, 32'hFFFF_FFFF,  32'd0,          3'b000, 1'b0, 1};
        vt[12] = '{OP_AND,  32'h0000_00F0,  32'h0000_003C,  4'd0,  0,  1'b0, 32'h0000_0030,  32'd0,          3'b000, 1'b0, 1};
        vt[13] = '{OP_OR,   32'h0000_00F0,  32'h0000_003C,  4'd1,  0,  1'b0, 32'h0000_00FC,  32'd0,          3'b000, 1'b0, 1};
        vt[14] = '{OP_DIV,  32'hFFFF_FFEF,  32'd5,          4'd2,  0,  1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFE,  3'b000, 1'b0, 34};
        vt[15] = '{4'hF,    32'd4,          32'd4,          4'd4,  0,  1'b1, 32'd0,          32'd0,          3'b000, 1'b1, 1};
        vt[16] = '{OP_MUL,  32'h0001_0000,  32'h0001_0000,  4'd6,  0,  1'b0, 32'd0,          32'd0,          3'b001, 1'b0, 4};

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_opcode = '0; cmd_tag = '0;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready_pre", 32'(cmd_ready), 32'd0);
        tick();
        chk("rel_cmd_ready_post", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 17; i++) do_req(vt[i]);

        // reset in the middle of a DIV wait aborts it and clears err_count
        cmd_valid = 1'b1; cmd_opcode = OP_DIV; cmd_a = 32'd17; cmd_b = 32'd5; cmd_tag = 4'd9;
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        chk("mid_wait_busy", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        errs = '0;
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_err_count", 32'(err_count), 32'd0);
        chk("abort_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_rsp_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel_pre", 32'(cmd_ready), 32'd0);
        tick();
        chk("abort_rel_post", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 40; k++) begin
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            if (k < 39) tick();
        end
        do_req('{OP_SUB, 32'd3, 32'd5, 4'd1, 0, 1'b0, 32'hFFFF_FFFE, 32'd0, 3'b010, 1'b0, 1});

        // randomized back-to-back traffic against a request-level model
        begin
            bit acc, hs, pv;
            int since, accepts, hss;
            since = 0; accepts = 0; hss = 0; pv = 0;
            cmd_valid = 1'b1;
            new_cmd();
            for (int c = 0; c < 4000; c++) begin
                acc = cmd_valid && cmd_ready;
                hs  = rsp_valid && rsp_ready;
                if (hs) begin
                    hss++;
                    if (q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
                    else begin
                        chk("rnd_result", rsp_result, q[0].r.r);
                        chk("rnd_rem", rsp_remainder, q[0].r.rem);
                        chk("rnd_flags", 32'(rsp_flags), 32'(q[0].r.f));
                        chk("rnd_tag", 32'(rsp_tag), 32'(q[0].tag));
                        chk("rnd_err", 32'(rsp_err), 32'(q[0].err));
                        void'(q.pop_front());
                    end
                end
                if (acc) begin
                    accepts++;
                    e.err = is_err(cmd_opcode, cmd_b);
                    e.r   = e.err ? '0 : alu_fn(cmd_opcode, cmd_a, cmd_b);
                    e.tag = cmd_tag;
                    e.lat = lat_of(cmd_opcode, cmd_b);
                    q.push_back(e);
                    if (e.err && errs != 16'hFFFF) errs++;
                end
                pv = rsp_valid;
                tick();
                since = acc ? 0 : since + 1;
                if (pv && !hs) chk("rnd_valid_hold", 32'(rsp_valid), 32'd1);
                if (rsp_valid && !pv) begin
                    if (q.size() == 0) chk("rnd_rise_empty", 32'd1, 32'd0);
                    else chk("rnd_latency", since, q[0].lat);
                    chk("rnd_err_count", 32'(err_count), 32'(errs));
                end
                if (q.size() > 1) chk("rnd_outstanding", q.size(), 1);
                if (c >= 3900) begin
                    cmd_valid = 1'b0;
                    rsp_ready = 1'b1;
                end else begin
                    if (acc || !cmd_valid) begin
                        new_cmd();
                        cmd_valid = $urandom_range(0, 3) != 0;
                    end
                    rsp_ready = $urandom_range(0, 1) == 1;
                end
            end
            chk("rnd_drained", q.size(), 0);
            chk("rnd_acc_eq_hs", accepts, hss);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the 32-bit ALU. Accepts one operation request at a time over a valid/ready command channel and drives the ALU operand and opcode inputs. Waits the opcode-dependent settle latency, captures result, remainder and flags, and returns them with the request tag over a valid/ready response channel. It sits between the instruction/control logic and the ALU datapath, screening illegal opcodes and divide-by-zero before they reach the ALU.

## Interface
Parameters:
- N, 32, operand/result width
- TAG_W, 4, request tag width
- MUL_LAT, 4, wait cycles for MUL (≥1)
- DIV_LAT, 34, wait cycles for DIV (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  request present
- cmd_ready  out  1  sequencer can accept
- cmd_a  in  N  operand A, signed
- cmd_b  in  N  operand B, signed
- cmd_opcode  in  4  AND 0000, OR 0001, XOR 0010, NOT 0011, NEG A 0100, NEG B 0101, ADD 0110, SUB 0111, MUL 1000, DIV 1001
- cmd_tag  in  TAG_W  opaque request ID
- alu_a, alu_b  out  N  registered operands to ALU
- alu_opcode  out  4  registered opcode to ALU
- alu_result, alu_remainder  in  N  ALU outputs
- alu_carry_out, alu_zero, alu_overflow  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result, rsp_remainder  out  N  captured ALU outputs
- rsp_flags  out  3  {overflow, carry_out, zero}
- rsp_tag  out  TAG_W  tag of the request
- rsp_err  out  1  request rejected
- err_count  out  16  saturating count of rejected requests

## Operation
- FSM states: IDLE, WAIT, RESP. One request outstanding at most.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready edge, latch tag and classify the request.
- Legal request: load alu_a/alu_b/alu_opcode from cmd_*. Load cnt = L−1, where L = MUL_LAT for MUL, DIV_LAT for DIV, and 1 otherwise. Go to WAIT.
- Error request (opcode 1010–1111, or DIV with cmd_b==0):
  - alu_* are not updated.
  - Go to WAIT with cnt=0.
  - At capture, rsp_result=0, rsp_remainder=0, rsp_flags=0, rsp_err=1.
  - err_count increments, saturating at 0xFFFF.
- WAIT: cnt≠0 → cnt−1. cnt==0 → capture ALU outputs (legal) or the error payload into rsp_* and go to RESP.
- RESP: rsp_valid=1, payload held stable until rsp_valid&&rsp_ready. On handshake edge go to IDLE.
- cmd_ready=0 in WAIT and RESP. cmd_* are ignored outside IDLE.
- The ALU is combinational. alu_* hold their last issued value between requests.

## Timing
- Reset (rst_n low, async): state IDLE. cmd_ready=0; it rises on the first clk edge after rst_n goes high. All other outputs reset to 0, including err_count. cnt=0.
- Latency: if the accept edge is E0, rsp_valid rises at edge E_L. Error requests rise at E1.
- alu_* are valid from E0 through the capture edge.
- Minimum turnaround: rsp handshake at edge E_R gives cmd_ready=1 after E_R, so the next accept occurs no earlier than E_R+1.
- rsp_ready high before rsp_valid has no effect. rsp_valid never drops without a handshake.
- rst_n asserted mid-WAIT or mid-RESP aborts the request; no response is produced. err_count clears.
- DIV/MUL results are taken verbatim from the ALU; the sequencer does no arithmetic except the b==0 compare.

## Test plan
- ADD a=5, b=7, tag=3, rsp_ready=1 → rsp_valid exactly 1 cycle after accept; rsp_result=12, rsp_flags=000, rsp_tag=3, rsp_err=0.
- MUL a=0xFFFFFFFF, b=3 (MUL_LAT=4) → rsp_valid exactly 4 cycles after accept; rsp_result=0xFFFFFFFD; alu_opcode=1000 held throughout WAIT.
- DIV a=100, b=0 → rsp_valid 1 cycle after accept; rsp_err=1, rsp_result=0, err_count=1, alu_opcode unchanged. Follow with opcode 1100 → rsp_err=1, err_count=2.
- DIV a=17, b=5 with rsp_ready=0 for 10 cycles after rsp_valid → rsp_result=3, rsp_remainder=2 stable; cmd_ready=0 throughout. Handshake → cmd_ready=1 the next cycle.
- Reset mid-WAIT of DIV (cycle 10 of 34) → all outputs 0 immediately; cmd_ready=1 one edge after release; a new SUB a=3, b=5 gives rsp_result=0xFFFFFFFE.
- cmd_valid held high with back-to-back requests → exactly one accept per response handshake, tags returned in order.
